// File: rtl/rap_mon_pkg.sv
// rap_mon_pkg
// Shared definitions for the approximate-adder error monitor:
//   - state_e      : monitor FSM states
//   - *_DEF        : default parameter values for the monitor
//   - SUM_MAX      : saturation ceiling of the default-width ED accumulator
//   - DRAIN_CYCLES : cycles needed to flush the two-stage sample pipeline
package rap_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned W_DEF      = 32;
  localparam int unsigned WINDOW_DEF = 1024;
  localparam int unsigned ACC_W_DEF  = 48;
  localparam int unsigned CNT_W_DEF  = 32;

  // Largest value the default-width error-distance sum can hold.
  localparam logic [ACC_W_DEF-1:0] SUM_MAX = {ACC_W_DEF{1'b1}};

  // One cycle per pipeline stage between the accept and the accumulators.
  localparam int unsigned DRAIN_CYCLES = 2;

endpackage

// File: rtl/rap_ed_calc.sv
// rap_ed_calc
// Combinational error-distance calculator. Recomputes the exact sum of the
// two operands and returns |exact - approx| at full W+1 bit width.
// Ports:
//   a_i, b_i      : operands that were fed to the approximate adder (W bits)
//   approx_sum_i  : approximate adder output (W+1 bits)
//   ed_o          : absolute error distance (W+1 bits)
module rap_ed_calc #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W:0]   approx_sum_i,
  output logic [W:0]   ed_o
);

  logic [W:0]   exactSum;
  logic [W+1:0] diff;

  // The exact sum is zero-extended so it can never overflow. The difference
  // carries one extra bit so its sign is unambiguous; the magnitude of any
  // negative result still fits in W+1 bits, so negating only the low bits
  // gives the correct absolute value even for the largest distances.
  always_comb begin
    exactSum = {1'b0, a_i} + {1'b0, b_i};
    diff     = {1'b0, exactSum} - {1'b0, approx_sum_i};
    if (diff[W+1]) begin
      ed_o = ~diff[W:0] + (W+1)'(1);
    end else begin
      ed_o = diff[W:0];
    end
  end

endmodule

// File: rtl/rap_err_monitor.sv
// rap_err_monitor
// Error-statistics monitor for a W-bit approximate adder. Each accepted
// sample (a, b, approx_sum) flows through a two-stage pipeline (register
// inputs, register error distance) and then updates the window accumulators.
// After WINDOW samples the FSM drains the pipeline, publishes the results
// and pulses done.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : begins a window, honoured only while idle
//   in_valid     : sample present on a, b, approx_sum
//   in_ready     : monitor accepts a sample this cycle
//   a, b         : operands (W bits)
//   approx_sum   : approximate sum (W+1 bits)
//   busy         : window in progress (RUN or DRAIN)
//   done         : one-cycle pulse when the result outputs are updated
//   err_count    : samples with nonzero error distance
//   max_ed       : largest error distance in the window
//   sum_ed       : saturating sum of error distances
//   sum_sat      : sum_ed hit its ceiling during the window
module rap_err_monitor
  import rap_mon_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [W:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic             sum_sat
);

  localparam int unsigned SCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(WINDOW - 1);
  localparam logic [1:0]     DRAIN_LAST  = 2'(DRAIN_CYCLES - 1);
  // Both branches are all-ones; the package constant is reused when the
  // accumulator keeps its default width.
  localparam logic [ACC_W-1:0] ACC_MAX =
    (ACC_W == ACC_W_DEF) ? ACC_W'(SUM_MAX) : {ACC_W{1'b1}};

  state_e           state_q;
  logic [SCW-1:0]   sampleCnt_q;
  logic [1:0]       drainCnt_q;
  logic             inReady_q;
  logic             busy_q;
  logic             done_q;

  logic             s1Valid_q;
  logic [W-1:0]     s1A_q;
  logic [W-1:0]     s1B_q;
  logic [W:0]       s1Approx_q;
  logic [W:0]       edComb;
  logic             s2Valid_q;
  logic [W:0]       s2Ed_q;

  logic [CNT_W-1:0] errCnt_q, errCnt_d;
  logic [W:0]       maxEd_q, maxEd_d;
  logic [ACC_W-1:0] sumEd_q, sumEd_d;
  logic             sumSat_q, sumSat_d;
  logic [ACC_W:0]   sumExt;

  logic [CNT_W-1:0] outErr_q;
  logic [W:0]       outMax_q;
  logic [ACC_W-1:0] outSum_q;
  logic             outSat_q;

  logic             accept;
  logic             startAccept;

  assign accept      = in_valid && inReady_q;
  assign startAccept = start && (state_q == IDLE);

  // Stage 1: capture the raw sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Approx_q <= '0;
    end else begin
      s1Valid_q <= accept;
      if (accept) begin
        s1A_q      <= a;
        s1B_q      <= b;
        s1Approx_q <= approx_sum;
      end
    end
  end

  rap_ed_calc #(
    .W (W)
  ) u_ed_calc (
    .a_i          (s1A_q),
    .b_i          (s1B_q),
    .approx_sum_i (s1Approx_q),
    .ed_o         (edComb)
  );

  // Stage 2: register the error distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Ed_q    <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Ed_q <= edComb;
      end
    end
  end

  // Next accumulator values for the error distance sitting in stage 2.
  // The sum is formed one bit wider so an overflow shows up as a carry,
  // which is then replaced by the ceiling and flagged sticky.
  always_comb begin
    errCnt_d = errCnt_q;
    maxEd_d  = maxEd_q;
    sumEd_d  = sumEd_q;
    sumSat_d = sumSat_q;
    sumExt   = {1'b0, sumEd_q} + (ACC_W+1)'(s2Ed_q);
    if (s2Ed_q != '0) begin
      errCnt_d = errCnt_q + CNT_W'(1);
    end
    if (s2Ed_q > maxEd_q) begin
      maxEd_d = s2Ed_q;
    end
    if (sumExt[ACC_W]) begin
      sumEd_d  = ACC_MAX;
      sumSat_d = 1'b1;
    end else begin
      sumEd_d = sumExt[ACC_W-1:0];
    end
  end

  // Internal accumulators: cleared by an honoured start, otherwise updated
  // once per valid stage-2 entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt_q <= '0;
      maxEd_q  <= '0;
      sumEd_q  <= '0;
      sumSat_q <= 1'b0;
    end else if (startAccept) begin
      errCnt_q <= '0;
      maxEd_q  <= '0;
      sumEd_q  <= '0;
      sumSat_q <= 1'b0;
    end else if (s2Valid_q) begin
      errCnt_q <= errCnt_d;
      maxEd_q  <= maxEd_d;
      sumEd_q  <= sumEd_d;
      sumSat_q <= sumSat_d;
    end
  end

  // Window FSM. in_ready, busy and done are registered alongside the state
  // so they change exactly on state transitions. Result outputs are only
  // written in DONE, so they hold the previous window while a new one runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      drainCnt_q  <= '0;
      inReady_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      outErr_q    <= '0;
      outMax_q    <= '0;
      outSum_q    <= '0;
      outSat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            sampleCnt_q <= '0;
            inReady_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (sampleCnt_q == LAST_SAMPLE) begin
              state_q    <= DRAIN;
              drainCnt_q <= '0;
              inReady_q  <= 1'b0;
            end else begin
              sampleCnt_q <= sampleCnt_q + SCW'(1);
            end
          end
        end
        DRAIN: begin
          if (drainCnt_q == DRAIN_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            drainCnt_q <= drainCnt_q + 2'd1;
          end
        end
        DONE: begin
          outErr_q <= errCnt_q;
          outMax_q <= maxEd_q;
          outSum_q <= sumEd_q;
          outSat_q <= sumSat_q;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          inReady_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = outErr_q;
  assign max_ed    = outMax_q;
  assign sum_ed    = outSum_q;
  assign sum_sat   = outSat_q;

endmodule

// File: tb/tb_rap_err_monitor.sv
// tb_rap_err_monitor
// Directed bench for rap_err_monitor. Three instances share the clock,
// reset and sample bus; each has its own start:
//   dut4   : WINDOW=4, ACC_W=48  (basic window, gaps/stray start, reset)
//   dutSat : WINDOW=5, ACC_W=34  (full-width negative difference, clamp)
//   dut1   : WINDOW=1            (back-to-back single-sample windows)
module tb_rap_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] aIn = '0;
  logic [31:0] bIn = '0;
  logic [32:0] approxIn = '0;
  logic        start4 = 1'b0;
  logic        startSat = 1'b0;
  logic        start1 = 1'b0;

  logic        inReady4, busy4, done4, sumSat4;
  logic [31:0] errCount4;
  logic [32:0] maxEd4;
  logic [47:0] sumEd4;

  logic        inReadySat, busySat, doneSat, sumSatSat;
  logic [31:0] errCountSat;
  logic [32:0] maxEdSat;
  logic [33:0] sumEdSat;

  logic        inReady1, busy1, done1, sumSat1;
  logic [31:0] errCount1;
  logic [32:0] maxEd1;
  logic [47:0] sumEd1;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic doneSeen;

  always #5 clk = ~clk;

  rap_err_monitor #(.W(32), .WINDOW(4), .ACC_W(48), .CNT_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(inValid),
    .in_ready(inReady4), .a(aIn), .b(bIn), .approx_sum(approxIn),
    .busy(busy4), .done(done4), .err_count(errCount4), .max_ed(maxEd4),
    .sum_ed(sumEd4), .sum_sat(sumSat4)
  );

  rap_err_monitor #(.W(32), .WINDOW(5), .ACC_W(34), .CNT_W(32)) dutSat (
    .clk(clk), .rst_n(rst_n), .start(startSat), .in_valid(inValid),
    .in_ready(inReadySat), .a(aIn), .b(bIn), .approx_sum(approxIn),
    .busy(busySat), .done(doneSat), .err_count(errCountSat),
    .max_ed(maxEdSat), .sum_ed(sumEdSat), .sum_sat(sumSatSat)
  );

  rap_err_monitor #(.W(32), .WINDOW(1), .ACC_W(48), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(inValid),
    .in_ready(inReady1), .a(aIn), .b(bIn), .approx_sum(approxIn),
    .busy(busy1), .done(done1), .err_count(errCount1), .max_ed(maxEd1),
    .sum_ed(sumEd1), .sum_sat(sumSat1)
  );

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic readyOf(input int sel);
    case (sel)
      0:       return inReady4;
      1:       return inReadySat;
      default: return inReady1;
    endcase
  endfunction

  function automatic logic doneOf(input int sel);
    case (sel)
      0:       return done4;
      1:       return doneSat;
      default: return done1;
    endcase
  endfunction

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input int sel);
    case (sel)
      0:       start4 = 1'b1;
      1:       startSat = 1'b1;
      default: start1 = 1'b1;
    endcase
    stepCycle();
    start4 = 1'b0;
    startSat = 1'b0;
    start1 = 1'b0;
  endtask

  // Idle for 'gap' cycles, then present one sample until the selected
  // instance accepts it. Returns just after the accepting edge.
  task automatic applyStimulus(input int sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [32:0] ap,
                               input int gap);
    logic accepted;
    int budget;
    inValid = 1'b0;
    for (int i = 0; i < gap; i++) stepCycle();
    aIn = a;
    bIn = b;
    approxIn = ap;
    inValid = 1'b1;
    accepted = 1'b0;
    budget = 0;
    while (!accepted && budget < 50) begin
      accepted = readyOf(sel);
      stepCycle();
      budget++;
    end
    inValid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'(accepted), 64'(1));
  endtask

  // Count cycles until the selected done pulse is seen; -1 on timeout.
  task automatic waitDone(input int sel, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      stepCycle();
      if (doneOf(sel)) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_in_ready", 64'(inReady4), 64'(0));
    checkOutput("rst_busy", 64'(busy4), 64'(0));
    checkOutput("rst_done", 64'(done4), 64'(0));
    checkOutput("rst_err_count", 64'(errCount4), 64'(0));
    checkOutput("rst_max_ed", 64'(maxEd4), 64'(0));
    checkOutput("rst_sum_ed", 64'(sumEd4), 64'(0));
    checkOutput("rst_sum_sat", 64'(sumSat4), 64'(0));

    // Window A: ED = 0, 16, 0, 3
    pulseStart(0);
    checkOutput("a_busy_run", 64'(busy4), 64'(1));
    checkOutput("a_ready_run", 64'(inReady4), 64'(1));
    applyStimulus(0, 32'd5, 32'd7, 33'd12, 0);
    applyStimulus(0, 32'hFF, 32'h01, 33'hF0, 0);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h1, 33'h1_0000_0000, 0);
    applyStimulus(0, 32'd10, 32'd20, 33'd33, 0);
    checkOutput("a_ready_drop", 64'(inReady4), 64'(0));
    checkOutput("a_busy_drain", 64'(busy4), 64'(1));
    stepCycle();
    stepCycle();
    checkOutput("a_done_early", 64'(done4), 64'(0));
    stepCycle();
    checkOutput("a_done_latency", 64'(done4), 64'(1));
    checkOutput("a_err_count", 64'(errCount4), 64'(2));
    checkOutput("a_max_ed", 64'(maxEd4), 64'(16));
    checkOutput("a_sum_ed", 64'(sumEd4), 64'(19));
    checkOutput("a_sum_sat", 64'(sumSat4), 64'(0));
    stepCycle();
    checkOutput("a_done_pulse", 64'(done4), 64'(0));
    checkOutput("a_busy_idle", 64'(busy4), 64'(0));

    // Window B: ED = 10, 0, 5, 20 with gaps and a stray start
    stepCycle();
    pulseStart(0);
    applyStimulus(0, 32'd1000, 32'd0, 33'd990, 2);
    pulseStart(0);
    checkOutput("b_hold_err_run", 64'(errCount4), 64'(2));
    applyStimulus(0, 32'd0, 32'd0, 33'd0, int'($urandom_range(0, 3)));
    applyStimulus(0, 32'd1, 32'd1, 33'd7, int'($urandom_range(0, 3)));
    applyStimulus(0, 32'd1000, 32'd0, 33'd980, int'($urandom_range(0, 3)));
    checkOutput("b_ready_drop", 64'(inReady4), 64'(0));
    // A fifth sample offered after the window is full must be ignored.
    aIn = 32'd0;
    bIn = 32'd0;
    approxIn = 33'h1_FFFF_FFFF;
    inValid = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("b_hold_sum_drain", 64'(sumEd4), 64'(19));
    checkOutput("b_done_early", 64'(done4), 64'(0));
    stepCycle();
    checkOutput("b_done_latency", 64'(done4), 64'(1));
    checkOutput("b_err_count", 64'(errCount4), 64'(3));
    checkOutput("b_max_ed", 64'(maxEd4), 64'(20));
    checkOutput("b_sum_ed", 64'(sumEd4), 64'(35));
    inValid = 1'b0;
    stepCycle();

    // Window C: reset asserted mid-window
    pulseStart(0);
    applyStimulus(0, 32'hFF, 32'h01, 33'hF0, 0);
    applyStimulus(0, 32'hFF, 32'h01, 33'hF0, 0);
    stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("c_rst_err_count", 64'(errCount4), 64'(0));
    checkOutput("c_rst_max_ed", 64'(maxEd4), 64'(0));
    checkOutput("c_rst_sum_ed", 64'(sumEd4), 64'(0));
    checkOutput("c_rst_busy", 64'(busy4), 64'(0));
    checkOutput("c_rst_in_ready", 64'(inReady4), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      doneSeen = doneSeen | done4;
    end
    checkOutput("c_no_done", 64'(doneSeen), 64'(0));
    checkOutput("c_idle_busy", 64'(busy4), 64'(0));

    // Saturation: five samples of ED = 2^32 into a 34-bit sum
    pulseStart(1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 32'd0, 32'd0, 33'h1_0000_0000, 0);
    end
    waitDone(1, 10, cyc);
    checkOutput("sat_done_latency", 64'(cyc), 64'(3));
    checkOutput("sat_err_count", 64'(errCountSat), 64'(5));
    checkOutput("sat_max_ed", 64'(maxEdSat), 64'h1_0000_0000);
    checkOutput("sat_sum_ed", 64'(sumEdSat), 64'h3_FFFF_FFFF);
    checkOutput("sat_sum_sat", 64'(sumSatSat), 64'(1));
    stepCycle();

    // WINDOW=1: two back-to-back windows
    pulseStart(2);
    applyStimulus(2, 32'd3, 32'd4, 33'd0, 0);
    checkOutput("w1_ready_drop", 64'(inReady1), 64'(0));
    waitDone(2, 10, cyc);
    checkOutput("w1_done_latency", 64'(cyc), 64'(3));
    checkOutput("w1_err_count", 64'(errCount1), 64'(1));
    checkOutput("w1_max_ed", 64'(maxEd1), 64'(7));
    checkOutput("w1_sum_ed", 64'(sumEd1), 64'(7));
    stepCycle();
    pulseStart(2);
    applyStimulus(2, 32'd10, 32'd10, 33'd20, 0);
    waitDone(2, 10, cyc);
    checkOutput("w1b_done_latency", 64'(cyc), 64'(3));
    checkOutput("w1b_err_count", 64'(errCount1), 64'(0));
    checkOutput("w1b_max_ed", 64'(maxEd1), 64'(0));
    checkOutput("w1b_sum_ed", 64'(sumEd1), 64'(0));
    checkOutput("w1b_sum_sat", 64'(sumSat1), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
